// File: rtl/ddr_test_sequencer_if.sv
// rtl/ddr_test_sequencer_if.sv - write/read master request bus between the sequencer and the AXI master pair
interface ddr_test_sequencer_if #(
    parameter int ADDR_WIDTH = 26
);
    logic                  wr_trig;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic                  wr_ready;
    logic                  wr_done;
    logic                  rd_trig;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic                  rd_ready;
    logic                  rd_done;
    logic                  rd_error;

    modport master (
        output wr_trig, wr_addr, wr_len,
        input  wr_ready, wr_done,
        output rd_trig, rd_addr, rd_len,
        input  rd_ready, rd_done, rd_error
    );

    modport slave (
        input  wr_trig, wr_addr, wr_len,
        output wr_ready, wr_done,
        input  rd_trig, rd_addr, rd_len,
        output rd_ready, rd_done, rd_error
    );
endinterface

// File: rtl/ddr_test_sequencer.sv
// rtl/ddr_test_sequencer.sv - DDR2 self-test sequencer: write burst, read back, count errors, sweep addresses
module ddr_test_sequencer #(
    parameter int         ADDR_WIDTH  = 26,
    parameter logic [7:0] BURST_LEN   = 8'd8,
    parameter int         ADDR_STEP   = 16,
    parameter int         ADDR_BASE   = 0,
    parameter int         ADDR_LAST   = 'h3FFF0,
    parameter int         ERR_TAIL    = 4,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_init_end,
    input  logic                       i_start,
    ddr_test_sequencer_if.master       bus,
    output logic                       o_busy,
    output logic [15:0]                o_pass_cnt,
    output logic [15:0]                o_err_cnt,
    output logic                       o_timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_NEXT, S_HALT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(ADDR_LAST);
    localparam logic [ADDR_WIDTH-1:0] C_STEP = ADDR_WIDTH'(ADDR_STEP);
    localparam int                    TAIL_W = $clog2(ERR_TAIL + 1);
    localparam logic [TAIL_W-1:0]     C_TAIL_END = TAIL_W'(ERR_TAIL - 1);
    localparam logic [12:0]           C_WDOG_END = 13'(TIMEOUT_CYC - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [12:0]           r_wdog;
    logic [TAIL_W-1:0]     r_tail;
    logic                  r_start_d;
    logic                  w_wr_trig;
    logic                  w_rd_trig;
    logic                  w_win;
    logic                  w_wdog_exp;
    logic                  w_wrap;
    logic                  w_start_rise;
    logic                  w_wdog_run;

    assign w_wdog_exp   = (r_wdog == C_WDOG_END);
    assign w_wrap       = (r_addr == C_LAST);
    assign w_start_rise = i_start && !r_start_d;
    assign w_wdog_run   = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT) ||
                          (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    // Error window spans the rd_trig cycle through the checker-pipeline tail.
    assign w_win        = w_rd_trig || (r_state == S_RD_WAIT) || (r_state == S_CHECK);

    always_comb begin
        w_next    = r_state;
        w_wr_trig = 1'b0;
        w_rd_trig = 1'b0;
        case (r_state)
            S_IDLE:    if (i_init_end && i_start) w_next = S_WR_REQ;
            S_WR_REQ: begin
                if (bus.wr_ready) begin
                    w_wr_trig = 1'b1;
                    w_next    = S_WR_WAIT;
                end else if (w_wdog_exp) begin
                    w_next = S_HALT;
                end
            end
            S_WR_WAIT: begin
                if (bus.wr_done)     w_next = S_RD_REQ;
                else if (w_wdog_exp) w_next = S_HALT;
            end
            S_RD_REQ: begin
                if (bus.rd_ready) begin
                    w_rd_trig = 1'b1;
                    w_next    = S_RD_WAIT;
                end else if (w_wdog_exp) begin
                    w_next = S_HALT;
                end
            end
            S_RD_WAIT: begin
                if (bus.rd_done)     w_next = S_CHECK;
                else if (w_wdog_exp) w_next = S_HALT;
            end
            S_CHECK:   if (r_tail == C_TAIL_END) w_next = S_NEXT;
            S_NEXT: begin
                if (!i_init_end || (w_wrap && !i_start)) w_next = S_IDLE;
                else                                     w_next = S_WR_REQ;
            end
            S_HALT:    if (!i_start) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= C_BASE;
            r_wdog     <= '0;
            r_tail     <= '0;
            r_start_d  <= 1'b0;
            o_pass_cnt <= '0;
            o_err_cnt  <= '0;
            o_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= i_start;
            r_tail    <= (r_state == S_CHECK) ? r_tail + 1'b1 : '0;
            // Watchdog restarts on each request so it bounds one REQ+WAIT leg.
            if ((w_next == S_WR_REQ || w_next == S_RD_REQ) && (w_next != r_state)) begin
                r_wdog <= '0;
            end else if (w_wdog_run) begin
                r_wdog <= r_wdog + 13'd1;
            end
            if (r_state == S_IDLE && w_start_rise) begin
                o_err_cnt  <= '0;
                o_pass_cnt <= '0;
                o_timeout  <= 1'b0;
                r_addr     <= C_BASE;
            end else begin
                if (w_next == S_HALT && r_state != S_HALT) o_timeout <= 1'b1;
                if (w_win && bus.rd_error && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
                if (r_state == S_NEXT) begin
                    if (w_wrap) begin
                        r_addr <= C_BASE;
                        if (o_pass_cnt != 16'hFFFF) o_pass_cnt <= o_pass_cnt + 16'd1;
                    end else begin
                        r_addr <= r_addr + C_STEP;
                    end
                end
            end
        end
    end

    assign bus.wr_trig = w_wr_trig;
    assign bus.wr_addr = r_addr;
    assign bus.wr_len  = BURST_LEN;
    assign bus.rd_trig = w_rd_trig;
    assign bus.rd_addr = r_addr;
    assign bus.rd_len  = BURST_LEN;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_HALT);
endmodule

// File: tb/tb_ddr_test_sequencer.sv
// tb/tb_ddr_test_sequencer.sv - self-checking bench for ddr_test_sequencer
module tb_ddr_test_sequencer;
    localparam int AW          = 26;
    localparam int ADDR_STEP   = 16;
    localparam int ADDR_LAST   = 32;
    localparam int ERR_TAIL    = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_end;
    logic        start;
    logic        busy;
    logic        tmo;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;

    ddr_test_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    ddr_test_sequencer #(
        .ADDR_WIDTH(AW), .BURST_LEN(8'd8), .ADDR_STEP(ADDR_STEP), .ADDR_BASE(0),
        .ADDR_LAST(ADDR_LAST), .ERR_TAIL(ERR_TAIL), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .i_init_end(init_end), .i_start(start), .bus(bus),
        .o_busy(busy), .o_pass_cnt(pass_cnt), .o_err_cnt(err_cnt), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wr_gap;
        int          wr_err;
        logic [31:0] mask;
        int          rd_lat;
        int          exp_lat;
        int          exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc_n, n_wr_trig, n_rd_trig, n_rd_done, exp_err, exp_addr, tail_end;
    int last_wr_trig, last_rd_trig, last_wr_addr, t0;
    int wr_cd, rd_cd, wr_hold, rd_hold, wr_lat, rd_lat, wr_err_n;
    int viol = 0;
    bit win, wr_hang, rand_mode, prev_wr, prev_rd, v_start;
    logic [31:0] rd_err_mask;
    vec_t vecs[6];

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive master responses, observe requests, update the reference model.
    task automatic cyc();
        bit e;
        int off;
        @(posedge clk); #1;
        cyc_n++;
        start = v_start;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        if (wr_cd > 0) begin wr_cd--; bus.wr_done = (wr_cd == 0) && !wr_hang; end
        if (rd_cd > 0) begin rd_cd--; bus.rd_done = (rd_cd == 0); end
        if (rand_mode && wr_hold == 0 && $urandom_range(0, 9) == 0) wr_hold = $urandom_range(1, 6);
        if (rand_mode && rd_hold == 0 && $urandom_range(0, 9) == 0) rd_hold = $urandom_range(1, 6);
        bus.wr_ready = (wr_cd == 0) && (wr_hold == 0);
        bus.rd_ready = (rd_cd == 0) && (rd_hold == 0);
        #1;
        if (bus.wr_trig) begin
            if (!bus.wr_ready || prev_wr || bus.rd_trig) viol++;
            chk("wr_addr", bus.wr_addr, exp_addr);
            chk("wr_len", bus.wr_len, 8);
            last_wr_addr = bus.wr_addr;
            last_wr_trig = cyc_n;
            n_wr_trig++;
            wr_cd = rand_mode ? $urandom_range(1, 15) : wr_lat;
        end
        if (bus.rd_trig) begin
            if (!bus.rd_ready || prev_rd) viol++;
            chk("rd_addr", bus.rd_addr, exp_addr);
            chk("rd_len", bus.rd_len, 8);
            exp_addr = (exp_addr == ADDR_LAST) ? 0 : exp_addr + ADDR_STEP;
            last_rd_trig = cyc_n;
            n_rd_trig++;
            win = 1'b1;
            rd_cd = rand_mode ? $urandom_range(1, 15) : rd_lat;
        end
        prev_wr = bus.wr_trig;
        prev_rd = bus.rd_trig;
        e = 1'b0;
        if (rand_mode) begin
            e = ($urandom_range(0, 5) == 0);
        end else begin
            off = cyc_n - last_rd_trig;
            if (off >= 0 && off < 32) e = rd_err_mask[off];
            off = cyc_n - last_wr_trig;
            if (off >= 1 && off <= wr_err_n) e = 1'b1;
        end
        bus.rd_error = e;
        if (bus.rd_done) begin n_rd_done++; tail_end = cyc_n + ERR_TAIL; end
        if (win && e) exp_err++;
        if (win && tail_end == cyc_n) begin win = 1'b0; tail_end = -1; end
        if (wr_hold > 0) wr_hold--;
        if (rd_hold > 0) rd_hold--;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_trig", bus.wr_trig, 0);
        chk("rst_rd_trig", bus.rd_trig, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_timeout", tmo, 0);
        v_start = 1'b0; start = 1'b0;
        bus.wr_ready = 1'b1; bus.rd_ready = 1'b1;
        bus.wr_done = 1'b0; bus.rd_done = 1'b0; bus.rd_error = 1'b0;
        wr_cd = 0; rd_cd = 0; wr_hold = 0; rd_hold = 0; wr_lat = 10; rd_lat = 10;
        wr_err_n = 0; rd_err_mask = '0; wr_hang = 1'b0; rand_mode = 1'b0;
        exp_addr = 0; exp_err = 0; win = 1'b0; tail_end = -1;
        n_wr_trig = 0; n_rd_trig = 0; n_rd_done = 0;
        last_wr_trig = -1000; last_rd_trig = -1000; last_wr_addr = -1;
        prev_wr = 1'b0; prev_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc_n = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        init_end = 1'b1; start = 1'b0; v_start = 1'b0;
        bus.wr_ready = 1'b1; bus.rd_ready = 1'b1;
        bus.wr_done = 1'b0; bus.rd_done = 1'b0; bus.rd_error = 1'b0;

        // {wr_gap, wr_err cycles, rd_error mask from rd_trig, rd_lat, wr_trig cycle, err_cnt}
        vecs[0] = '{0,  0, 32'h0000_0000, 10, 2,  0};
        vecs[1] = '{0,  5, 32'h0000_3038, 10, 2,  5};
        vecs[2] = '{0,  0, 32'h0001_C001, 10, 2,  2};
        vecs[3] = '{0,  0, 32'h0000_FFFF, 3,  2,  8};
        vecs[4] = '{20, 0, 32'h0000_0000, 10, 21, 0};
        vecs[5] = '{3,  0, 32'h0000_0000, 10, 4,  0};

        for (int i = 0; i < 6; i++) begin
            reset_dut();
            wr_hold = vecs[i].wr_gap;
            wr_err_n = vecs[i].wr_err;
            rd_err_mask = vecs[i].mask;
            rd_lat = vecs[i].rd_lat;
            v_start = 1'b1;
            for (int k = 0; k < 100 && n_wr_trig < 1; k++) cyc();
            chk($sformatf("vec%0d_trig_cycle", i), last_wr_trig, vecs[i].exp_lat);
            for (int k = 0; k < 200 && n_wr_trig < 2; k++) cyc();
            chk($sformatf("vec%0d_pairs", i), n_wr_trig, 2);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
        end

        // Sweep wrap at ADDR_LAST, then a write that never completes.
        reset_dut();
        v_start = 1'b1;
        for (int k = 0; k < 300 && n_wr_trig < 3; k++) cyc();
        chk("wrap_pass_before", pass_cnt, 0);
        chk("wrap_third_addr", last_wr_addr, 32);
        for (int k = 0; k < 300 && n_wr_trig < 4; k++) cyc();
        chk("wrap_pass_after", pass_cnt, 1);
        chk("wrap_addr", last_wr_addr, 0);
        for (int k = 0; k < 100 && n_rd_done < 4; k++) cyc();
        wr_hang = 1'b1;
        for (int k = 0; k < 100 && n_wr_trig < 5; k++) cyc();
        chk("hang_addr", last_wr_addr, 16);
        t0 = cyc_n;
        for (int k = 0; k < TIMEOUT_CYC + 200 && busy; k++) cyc();
        chk("halt_cycles", cyc_n - t0, TIMEOUT_CYC);
        chk("halt_timeout", tmo, 1);
        for (int k = 0; k < 5; k++) cyc();
        chk("halt_hold_busy", busy, 0);
        chk("halt_hold_timeout", tmo, 1);
        chk("halt_no_trig", n_wr_trig, 5);
        wr_hang = 1'b0; wr_cd = 0;
        v_start = 1'b0;
        cyc(); cyc();
        v_start = 1'b1;
        exp_addr = 0;
        cyc(); cyc();
        chk("restart_timeout", tmo, 0);
        chk("restart_pass", pass_cnt, 0);
        chk("restart_trig", n_wr_trig, 6);
        chk("restart_addr", last_wr_addr, 0);

        // Reset during RD_WAIT, then stop mid-sweep.
        reset_dut();
        rd_err_mask = 32'h0000_0002;
        v_start = 1'b1;
        for (int k = 0; k < 200 && n_rd_trig < 2; k++) cyc();
        cyc(); cyc();
        chk("pre_rst_err", err_cnt, 2);
        chk("pre_rst_addr", bus.rd_addr, 16);
        reset_dut();
        v_start = 1'b1;
        for (int k = 0; k < 200 && n_wr_trig < 2; k++) cyc();
        v_start = 1'b0;
        for (int k = 0; k < 300 && busy; k++) cyc();
        chk("stop_busy", busy, 0);
        chk("stop_pairs", n_rd_done, 3);
        chk("stop_pass", pass_cnt, 1);
        chk("stop_addr", bus.wr_addr, 0);
        for (int k = 0; k < 20; k++) cyc();
        chk("stop_no_trig", n_wr_trig, 3);

        // Randomized traffic against the window/sweep model.
        reset_dut();
        rand_mode = 1'b1;
        v_start = 1'b1;
        for (int k = 0; k < 8000 && n_rd_done < 40; k++) cyc();
        chk("rand_progress", n_rd_done >= 40, 1);
        v_start = 1'b0;
        for (int k = 0; k < 3000 && busy; k++) cyc();
        chk("rand_busy", busy, 0);
        chk("rand_sweep_end", n_rd_done % 3, 0);
        chk("rand_pass", pass_cnt, n_rd_done / 3);
        chk("rand_err", err_cnt, exp_err);
        rand_mode = 1'b0;
        v_start = 1'b1;
        cyc(); cyc();
        chk("rand_clear_err", err_cnt, 0);
        chk("rand_clear_pass", pass_cnt, 0);

        chk("protocol_viol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
